// File: rtl/f_ifu.sv
// F-stage fetch unit: owns the architectural PC, fetches over a variable-latency
// req/ack port, buffers a returned word across hazard stalls, and flags AdEL.
module f_ifu #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc,
  input  logic        stall,
  output logic        i_req,
  output logic [31:0] i_inst_addr,
  input  logic        i_ack,
  input  logic [31:0] i_rdata,
  output logic [31:0] F_pc,
  output logic [31:0] F_instr,
  output logic        F_valid,
  output logic        F_excAdEL
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] buf_reg;
  logic        buf_valid_reg;

  logic exc;
  logic hit;
  logic advance;

  always_comb begin
    exc = (pc_reg[1:0] != 2'b00) || (pc_reg < IM_BASE) || (pc_reg > IM_LIMIT);
    // Never request an illegal address; reset gating drops req at once on async reset.
    i_req       = (state_reg == FETCH) && !exc && !reset;
    hit         = i_req && i_ack;
    F_valid     = exc || buf_valid_reg || hit;
    F_excAdEL   = exc;
    F_pc        = pc_reg;
    i_inst_addr = pc_reg;
    if (exc) begin
      F_instr = 32'h0;
    end else if (buf_valid_reg) begin
      F_instr = buf_reg;
    end else if (hit) begin
      F_instr = i_rdata;
    end else begin
      F_instr = 32'h0;
    end
    advance = F_valid && !stall;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg        <= RESET_PC;
      buf_reg       <= 32'h0;
      buf_valid_reg <= 1'b0;
      state_reg     <= FETCH;
    end else if (advance) begin
      pc_reg        <= npc;
      buf_valid_reg <= 1'b0;
      state_reg     <= FETCH;
    end else if ((state_reg == FETCH) && hit && stall) begin
      // Capture the word now; the memory will not repeat it once req drops.
      buf_reg       <= i_rdata;
      buf_valid_reg <= 1'b1;
      state_reg     <= HOLD;
    end
  end

endmodule

// File: tb/tb_f_ifu.sv
// Self-checking bench for f_ifu: latency-configurable memory model and a
// scoreboard of expected (pc, instr, exc) entries consumed on each advance.
module tb_f_ifu;

  logic        clk;
  logic        reset;
  logic [31:0] npc;
  logic        stall;
  logic        i_req;
  logic [31:0] i_inst_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic [31:0] F_pc;
  logic [31:0] F_instr;
  logic        F_valid;
  logic        F_excAdEL;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int n_checks = 0;
  int n_fail   = 0;

  int          latency;
  int          lat_cnt;
  logic        npc_follow;
  logic [31:0] npc_val;
  logic [31:0] ovr_addr;
  logic [31:0] ovr_data;

  f_ifu dut (
    .clk(clk), .reset(reset), .npc(npc), .stall(stall),
    .i_req(i_req), .i_inst_addr(i_inst_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .F_pc(F_pc), .F_instr(F_instr), .F_valid(F_valid), .F_excAdEL(F_excAdEL)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ack arrives `latency` cycles after req rises for an address.
  always @(posedge clk) begin
    if (!i_req || i_ack) lat_cnt <= 0;
    else lat_cnt <= lat_cnt + 1;
  end
  assign i_ack   = i_req && (lat_cnt == latency);
  assign i_rdata = (i_inst_addr == ovr_addr) ? ovr_data : (i_inst_addr ^ 32'hA5A5_0000);
  assign npc     = npc_follow ? (F_pc + 32'd4) : npc_val;

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr, input logic exc);
    exp_t r;
    r.pc = pc;
    r.instr = instr;
    r.exc = exc;
    return r;
  endfunction

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; stall = 1'b0; latency = 0; npc_follow = 1'b1;
    @(negedge clk);
    n_checks++;
    if (i_req !== 1'b0 || F_valid !== 1'b0 || F_instr !== 32'h0 || F_excAdEL !== 1'b0 ||
        F_pc !== 32'h3000 || i_inst_addr !== 32'h3000) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b valid=%b instr=%h exc=%b pc=%h addr=%h, need 0 0 0 0 3000 3000",
               i_req, F_valid, F_instr, F_excAdEL, F_pc, i_inst_addr);
    end
    latency = 5;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (i_req !== 1'b1 || i_inst_addr !== 32'h3000 || F_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: req=%b addr=%h valid=%b, need 1 3000 0", i_req, i_inst_addr, F_valid);
    end
    $display("test_reset done");
  endtask

  task automatic test_stream;
    do_reset();
    latency = 0; stall = 1'b0; npc_follow = 1'b1;
    for (int k = 0; k < 5; k++) sb.push_back(mk(32'h3000 + 32'(4*k), (32'h3000 + 32'(4*k)) ^ 32'hA5A5_0000, 1'b0));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (!(F_valid === 1'b1 && stall === 1'b0) || sb.size() == 0) begin
        n_fail++;
        $display("FAIL stream_valid cycle %0d: valid=%b, need 1", k, F_valid);
      end else begin
        e = sb.pop_front();
        if (F_pc !== e.pc || F_instr !== e.instr || F_excAdEL !== e.exc) begin
          n_fail++;
          $display("FAIL stream_data: pc=%h instr=%h exc=%b, need %h %h %b", F_pc, F_instr, F_excAdEL, e.pc, e.instr, e.exc);
        end
      end
      $display("stream cycle %0d pc=%h instr=%h", k, F_pc, F_instr);
      next_cycle();
    end
  endtask

  task automatic test_latency2;
    logic        exp_valid [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] exp_addr  [6] = '{32'h3000, 32'h3000, 32'h3000, 32'h3004, 32'h3004, 32'h3004};
    do_reset();
    latency = 2; stall = 1'b0; npc_follow = 1'b1;
    sb.push_back(mk(32'h3000, 32'h3000 ^ 32'hA5A5_0000, 1'b0));
    sb.push_back(mk(32'h3004, 32'h3004 ^ 32'hA5A5_0000, 1'b0));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_checks++;
      if (i_req !== 1'b1 || i_inst_addr !== exp_addr[k] || F_valid !== exp_valid[k]) begin
        n_fail++;
        $display("FAIL lat2_handshake cycle %0d: req=%b addr=%h valid=%b, need 1 %h %b",
                 k, i_req, i_inst_addr, F_valid, exp_addr[k], exp_valid[k]);
      end
      if (F_valid === 1'b1 && stall === 1'b0 && sb.size() != 0) begin
        e = sb.pop_front();
        n_checks++;
        if (F_pc !== e.pc || F_instr !== e.instr) begin
          n_fail++;
          $display("FAIL lat2_data: pc=%h instr=%h, need %h %h", F_pc, F_instr, e.pc, e.instr);
        end
      end
      $display("lat2 cycle %0d addr=%h valid=%b", k, i_inst_addr, F_valid);
      next_cycle();
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL lat2_drain: %0d entries left, need 0", sb.size());
    end
  endtask

  task automatic test_stall_capture;
    do_reset();
    latency = 0; stall = 1'b0; npc_follow = 1'b1;
    ovr_addr = 32'h3004; ovr_data = 32'h2408_0001;
    sb.push_back(mk(32'h3000, 32'h3000 ^ 32'hA5A5_0000, 1'b0));
    sb.push_back(mk(32'h3004, 32'h2408_0001, 1'b0));
    for (int k = 0; k < 7; k++) begin
      stall = (k >= 1 && k <= 4);
      npc_follow = !(k >= 2 && k <= 4);
      npc_val = 32'hDEAD_BEE0;
      @(negedge clk);
      if (k >= 2 && k <= 4) begin
        n_checks++;
        if (i_req !== 1'b0 || F_valid !== 1'b1 || F_instr !== 32'h2408_0001 || F_pc !== 32'h3004) begin
          n_fail++;
          $display("FAIL stall_hold cycle %0d: req=%b valid=%b instr=%h pc=%h, need 0 1 24080001 3004",
                   k, i_req, F_valid, F_instr, F_pc);
        end
      end
      if (k == 6) begin
        n_checks++;
        if (F_pc !== 32'h3008 || i_req !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_release: pc=%h req=%b, need 3008 1", F_pc, i_req);
        end
      end else if (F_valid === 1'b1 && stall === 1'b0) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL stall_extra: unexpected advance pc=%h", F_pc);
        end else begin
          e = sb.pop_front();
          if (F_pc !== e.pc || F_instr !== e.instr) begin
            n_fail++;
            $display("FAIL stall_data: pc=%h instr=%h, need %h %h", F_pc, F_instr, e.pc, e.instr);
          end
        end
      end
      $display("stall cycle %0d stall=%b pc=%h instr=%h req=%b", k, stall, F_pc, F_instr, i_req);
      next_cycle();
    end
    stall = 1'b0; npc_follow = 1'b1; ovr_addr = 32'hFFFF_FFFF;
  endtask

  task automatic test_jump;
    do_reset();
    latency = 0; stall = 1'b0; npc_follow = 1'b0; npc_val = 32'h3400;
    sb.push_back(mk(32'h3000, 32'h3000 ^ 32'hA5A5_0000, 1'b0));
    sb.push_back(mk(32'h3400, 32'h3400 ^ 32'hA5A5_0000, 1'b0));
    for (int k = 0; k < 6; k++) begin
      stall = (k >= 1 && k <= 3);
      npc_val = (k == 0) ? 32'h3400 : (k <= 3) ? (32'hBAD0_0000 + 32'(k)) : 32'h3404;
      @(negedge clk);
      if (k >= 1 && k <= 3) begin
        n_checks++;
        if (F_pc !== 32'h3400 || i_inst_addr !== 32'h3400) begin
          n_fail++;
          $display("FAIL jump_target cycle %0d: pc=%h addr=%h, need 3400", k, F_pc, i_inst_addr);
        end
      end
      if (k == 5) begin
        n_checks++;
        if (F_pc !== 32'h3404) begin
          n_fail++;
          $display("FAIL jump_next: pc=%h, need 3404", F_pc);
        end
      end else if (F_valid === 1'b1 && stall === 1'b0) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL jump_extra: unexpected advance pc=%h", F_pc);
        end else begin
          e = sb.pop_front();
          if (F_pc !== e.pc || F_instr !== e.instr) begin
            n_fail++;
            $display("FAIL jump_data: pc=%h instr=%h, need %h %h", F_pc, F_instr, e.pc, e.instr);
          end
        end
      end
      $display("jump cycle %0d npc=%h pc=%h", k, npc, F_pc);
      next_cycle();
    end
    stall = 1'b0;
  endtask

  task automatic test_exc;
    logic [31:0] tgt [5] = '{32'h3002, 32'h7000, 32'h6FFC, 32'h2FFC, 32'h3000};
    logic        bad [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] pcs [6];
    do_reset();
    latency = 0; stall = 1'b0; npc_follow = 1'b0;
    pcs[0] = 32'h3000;
    for (int k = 0; k < 5; k++) pcs[k+1] = tgt[k];
    for (int k = 0; k < 6; k++)
      sb.push_back(mk(pcs[k], bad[k] ? 32'h0 : (pcs[k] ^ 32'hA5A5_0000), bad[k]));
    for (int k = 0; k < 6; k++) begin
      npc_val = (k < 5) ? tgt[k] : 32'h3004;
      @(negedge clk);
      n_checks++;
      if (i_req !== !bad[k]) begin
        n_fail++;
        $display("FAIL exc_req pc=%h: req=%b, need %b", F_pc, i_req, !bad[k]);
      end
      n_checks++;
      if (F_valid !== 1'b1 || sb.size() == 0) begin
        n_fail++;
        $display("FAIL exc_valid pc=%h: valid=%b, need 1", F_pc, F_valid);
      end else begin
        e = sb.pop_front();
        if (F_pc !== e.pc || F_instr !== e.instr || F_excAdEL !== e.exc) begin
          n_fail++;
          $display("FAIL exc_data: pc=%h instr=%h exc=%b, need %h %h %b", F_pc, F_instr, F_excAdEL, e.pc, e.instr, e.exc);
        end
      end
      $display("exc cycle %0d pc=%h exc=%b req=%b", k, F_pc, F_excAdEL, i_req);
      next_cycle();
    end
    npc_follow = 1'b1;
  endtask

  task automatic test_async_reset;
    do_reset();
    latency = 1; stall = 1'b0; npc_follow = 1'b1;
    next_cycle();
    next_cycle();
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (i_req !== 1'b0 || F_valid !== 1'b0 || F_instr !== 32'h0 || F_excAdEL !== 1'b0 ||
        F_pc !== 32'h3000 || i_inst_addr !== 32'h3000) begin
      n_fail++;
      $display("FAIL async_reset: req=%b valid=%b instr=%h exc=%b pc=%h addr=%h, need 0 0 0 0 3000 3000",
               i_req, F_valid, F_instr, F_excAdEL, F_pc, i_inst_addr);
    end
    next_cycle();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (i_req !== 1'b1 || i_inst_addr !== 32'h3000 || F_valid !== (k == 1)) begin
        n_fail++;
        $display("FAIL async_release cycle %0d: req=%b addr=%h valid=%b, need 1 3000 %b",
                 k, i_req, i_inst_addr, F_valid, (k == 1));
      end
      $display("async release cycle %0d addr=%h valid=%b", k, i_inst_addr, F_valid);
      next_cycle();
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; latency = 0; npc_follow = 1'b1;
    npc_val = 32'h0; ovr_addr = 32'hFFFF_FFFF; ovr_data = 32'h0;
    test_reset();
    test_stream();
    test_latency2();
    test_stall_capture();
    test_jump();
    test_exc();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
